// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the instruction-memory boot loader.
//   loader_state_t : loader FSM state encoding
//   WORD_BYTES     : bytes packed into one instruction word
//   HDR_BYTES      : bytes in the big-endian word-count header
//   IDX_W          : width of the byte index inside a word
// -----------------------------------------------------------------------------
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_HI = 3'd1,
        ST_HDR_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } loader_state_t;

    localparam int WORD_BYTES = 4;
    localparam int HDR_BYTES  = 2;
    localparam int IDX_W      = $clog2(WORD_BYTES);

endpackage : loader_pkg

// File: rtl/imem_boot_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Packs accepted bytes big-endian into 32-bit words: the first byte of a word
// lands in [31:24], the last in [7:0].
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : restart packing at byte 0 (new load)
//   byte_valid  : a byte is consumed this cycle
//   byte_data   : the byte
//   word_valid  : combinational, high while the last byte of a word is consumed
//   word        : assembled word, valid together with word_valid
// -----------------------------------------------------------------------------
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam int                 SH_W     = (WORD_BYTES - 1) * 8;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(WORD_BYTES - 1);

    logic [IDX_W-1:0] idx_q;
    logic [SH_W-1:0]  shreg_q;

    // The final byte is not stored; it is spliced straight into the word so
    // the word is available in the same cycle it completes.
    assign word_valid = byte_valid && (idx_q == LAST_IDX);
    assign word       = {shreg_q, byte_data};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            shreg_q <= '0;
        end else if (clr) begin
            idx_q   <= '0;
        end else if (byte_valid) begin
            shreg_q <= {shreg_q[SH_W-9:0], byte_data};
            idx_q   <= word_valid ? '0 : idx_q + 1'b1;
        end
    end

endmodule : byte_packer

// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
// Receives a program image as a byte stream (2-byte big-endian word count,
// then count*4 data bytes), writes the packed words into instruction memory
// starting at BASE_ADDR, and holds the core in reset until loading is done.
//
// Optional build macro: LOADER_CHECKSUM_EN
//   When defined, one extra byte follows the data and must equal the XOR of
//   all data bytes; a mismatch ends in ERR. Undefined: no checksum byte.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : pulse, begins a load from IDLE, DONE or ERR
//   in_valid/in_data    : byte stream, transfers when in_valid && in_ready
//   in_ready            : loader accepts a byte this cycle
//   imem_wr_en          : one-cycle write strobe per word
//   imem_wr_addr        : byte address of the word being written
//   imem_wr_data        : instruction word
//   cpu_rst_n           : core reset, released only in DONE
//   done / error        : load finished / load rejected
// -----------------------------------------------------------------------------
module imem_boot_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_wr_en,
    output logic [31:0] imem_wr_addr,
    output logic [31:0] imem_wr_data,
    output logic        cpu_rst_n,
    output logic        done,
    output logic        error
);

    loader_state_t state_q, state_d;
    logic [15:0]   hdr_count_q;
    logic [15:0]   word_cnt_q;
    logic [15:0]   hdr_next;
    logic          accept;
    logic          start_load;
    logic          last_word;
    logic          pk_valid;
    logic [31:0]   pk_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    xor_q;
`endif

    // in_ready depends on state only, never on in_valid.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            ST_HDR_HI, ST_HDR_LO, ST_DATA: in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM:                       in_ready = 1'b1;
`endif
            default:                       in_ready = 1'b0;
        endcase
    end

    assign accept    = in_valid && in_ready;
    assign hdr_next  = {hdr_count_q[15:8], in_data};
    // word_cnt_q still names the word in flight until its write cycle ends.
    assign last_word = (word_cnt_q == hdr_count_q - 16'd1);

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (start_load),
        .byte_valid (accept && (state_q == ST_DATA)),
        .byte_data  (in_data),
        .word_valid (pk_valid),
        .word       (pk_word)
    );

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        start_load = 1'b0;
        cpu_rst_n  = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                cpu_rst_n = (state_q == ST_DONE);
                done      = (state_q == ST_DONE);
                error     = (state_q == ST_ERR);
                if (start) begin
                    state_d    = ST_HDR_HI;
                    start_load = 1'b1;
                end
            end
            ST_HDR_HI: if (accept) state_d = ST_HDR_LO;
            ST_HDR_LO: begin
                if (accept) begin
                    if (hdr_next == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_DONE;
`endif
                    end else if (int'(hdr_next) > MAX_WORDS) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
`ifdef LOADER_CHECKSUM_EN
                // Leave on the last byte so a checksum byte arriving during
                // the final write cycle is taken by CSUM, not by the packer.
                if (pk_valid && last_word) state_d = ST_CSUM;
`else
                if (imem_wr_en && last_word) state_d = ST_DONE;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (accept) state_d = (in_data == xor_q) ? ST_DONE : ST_ERR;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            hdr_count_q  <= '0;
            word_cnt_q   <= '0;
            imem_wr_en   <= 1'b0;
            imem_wr_addr <= BASE_ADDR;
            imem_wr_data <= '0;
        end else begin
            state_q    <= state_d;
            imem_wr_en <= pk_valid;
            if (pk_valid) imem_wr_data <= pk_word;

            if (state_q == ST_HDR_HI && accept) hdr_count_q[15:8] <= in_data;

            if (state_q == ST_HDR_LO && accept) begin
                hdr_count_q[7:0] <= in_data;
                word_cnt_q       <= '0;
                imem_wr_addr     <= BASE_ADDR;
            end else if (imem_wr_en) begin
                // Address advances after the write cycle; wraps modulo 2^32.
                imem_wr_addr <= imem_wr_addr + 32'd4;
                word_cnt_q   <= word_cnt_q + 16'd1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xor_q <= '0;
        end else if (start_load) begin
            xor_q <= '0;
        end else if (state_q == ST_DATA && accept) begin
            xor_q <= xor_q ^ in_data;
        end
    end
`endif

endmodule : imem_boot_loader

// File: tb/tb_imem_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_boot_loader
// Directed-vector bench for imem_boot_loader. Writes are captured by a
// monitor on the falling edge and compared with hand-computed words.
// Build with LOADER_CHECKSUM_EN to exercise the checksum variant.
// -----------------------------------------------------------------------------
module tb_imem_boot_loader;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_wr_en;
    logic [31:0] imem_wr_addr;
    logic [31:0] imem_wr_data;
    logic        cpu_rst_n;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [7:0]  img[$];

    always #5 clk = ~clk;

    imem_boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(256)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_wr_en   (imem_wr_en),
        .imem_wr_addr (imem_wr_addr),
        .imem_wr_data (imem_wr_data),
        .cpu_rst_n    (cpu_rst_n),
        .done         (done),
        .error        (error)
    );

    always @(negedge clk) begin
        if (rst_n && imem_wr_en) begin
            log_addr.push_back(imem_wr_addr);
            log_data.push_back(imem_wr_data);
        end
    end

    // Present one byte and hold it until accepted; returns at edge + 1.
    task automatic send_byte(input logic [7:0] b, output int waited);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout: in_ready=%b required 1", in_ready);
        end else begin
            @(posedge clk); #1;
        end
        waited   = n;
        in_valid = 1'b0;
        in_data  = 8'hEE;
    endtask

    // Sends img (header + data, plus checksum when built with it). gap idle
    // cycles with in_valid=0 between bytes; in_ready low during a gap is
    // counted as a stall.
    task automatic send_image(input int gap, input logic bad_csum, output int stalls);
        logic [7:0] x = 8'h00;
        int w;
        stalls = 0;
        for (int i = 0; i < img.size(); i++) begin
            send_byte(img[i], w);
            stalls += w;
            if (i >= 2) x ^= img[i];
            if (gap > 0 && i < img.size() - 1) begin
                for (int g = 0; g < gap; g++) begin
                    if (!in_ready) stalls++;
                    @(posedge clk); #1;
                end
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(bad_csum ? (x ^ 8'h01) : x, w);
        stalls += w;
`endif
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Compares the writes logged since index base with two expected words.
    task automatic check_two_writes(input string name, input int base,
                                    input logic [31:0] d0, input logic [31:0] d1);
        logic [31:0] exp_d[2];
        exp_d[0] = d0;
        exp_d[1] = d1;
        checks++;
        if (log_addr.size() - base !== 2) begin
            errors++;
            $display("FAIL %s_count: writes=%0d required 2", name, log_addr.size() - base);
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (log_addr[base+i] !== BASE + 32'(4*i) || log_data[base+i] !== exp_d[i]) begin
                    errors++;
                    $display("FAIL %s_word%0d: got %h@%h required %h@%h", name, i,
                             log_data[base+i], log_addr[base+i], exp_d[i], BASE + 32'(4*i));
                end
            end
        end
    endtask

    task automatic load_two_word_image();
        img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        #12;
        checks++;
        if ({in_ready, imem_wr_en, cpu_rst_n, done, error} !== 5'b0 ||
            imem_wr_addr !== BASE || imem_wr_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: rdy/we/cpu/done/err=%b addr=%h data=%h required 00000 %h 0",
                     {in_ready, imem_wr_en, cpu_rst_n, done, error}, imem_wr_addr, imem_wr_data, BASE);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_data();
        int w;
        int base;
        load_two_word_image();
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(img[i], w);
        // First word is in its write cycle right now.
        checks++;
        if (imem_wr_en !== 1'b1 || imem_wr_data !== 32'h2008_0005) begin
            errors++;
            $display("FAIL mid_first_write: we=%b data=%h required 1 20080005", imem_wr_en, imem_wr_data);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, imem_wr_en, cpu_rst_n, done, error} !== 5'b0 ||
            imem_wr_addr !== BASE || imem_wr_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_data: rdy/we/cpu/done/err=%b addr=%h data=%h required 00000 %h 0",
                     {in_ready, imem_wr_en, cpu_rst_n, done, error}, imem_wr_addr, imem_wr_data, BASE);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0 || cpu_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: in_ready=%b cpu_rst_n=%b required 0 0", in_ready, cpu_rst_n);
        end
        // A clean reload must start at byte 0 of a word.
        base = log_addr.size();
        pulse_start();
        send_image(0, 1'b0, w);
        @(posedge clk); #1;
        check_two_writes("reload_after_reset", base, 32'h2008_0005, 32'h8C09_0004);
    endtask

    task automatic test_back_to_back();
        int stalls;
        int base = log_addr.size();
        load_two_word_image();
        pulse_start();
        send_image(0, 1'b0, stalls);
        checks++;
        if (stalls !== 0) begin
            errors++;
            $display("FAIL b2b_stalls: stalls=%0d required 0", stalls);
        end
`ifdef LOADER_CHECKSUM_EN
        checks++;
        if ({cpu_rst_n, done, error} !== 3'b110) begin
            errors++;
            $display("FAIL b2b_done: cpu/done/err=%b required 110", {cpu_rst_n, done, error});
        end
`else
        checks++;
        if (imem_wr_en !== 1'b1 || cpu_rst_n !== 1'b0 || imem_wr_addr !== BASE + 32'd4) begin
            errors++;
            $display("FAIL b2b_last_write: we=%b cpu=%b addr=%h required 1 0 %h",
                     imem_wr_en, cpu_rst_n, imem_wr_addr, BASE + 32'd4);
        end
        @(posedge clk); #1;
        checks++;
        if ({cpu_rst_n, done, error, in_ready, imem_wr_en} !== 5'b11000) begin
            errors++;
            $display("FAIL b2b_done: cpu/done/err/rdy/we=%b required 11000",
                     {cpu_rst_n, done, error, in_ready, imem_wr_en});
        end
`endif
        check_two_writes("b2b", base, 32'h2008_0005, 32'h8C09_0004);
    endtask

    task automatic test_valid_gaps();
        int stalls;
        int base = log_addr.size();
        load_two_word_image();
        pulse_start();
        send_image(1, 1'b0, stalls);
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (stalls !== 0) begin
            errors++;
            $display("FAIL gaps_ready: stalls=%0d required 0", stalls);
        end
        checks++;
        if ({cpu_rst_n, done, in_ready} !== 3'b110) begin
            errors++;
            $display("FAIL gaps_done: cpu/done/rdy=%b required 110", {cpu_rst_n, done, in_ready});
        end
        check_two_writes("gaps", base, 32'h2008_0005, 32'h8C09_0004);
    endtask

    task automatic test_header_limits();
        int w;
        int base;
        // count == MAX_WORDS is accepted: loader moves on to DATA.
        pulse_start();
        send_byte(8'h01, w);
        send_byte(8'h00, w);
        checks++;
        if (in_ready !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL max_words_accepted: in_ready=%b error=%b required 1 0", in_ready, error);
        end
        // Abandon that load with a reset.
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        base = log_addr.size();
        pulse_start();
        send_byte(8'h01, w);
        send_byte(8'h01, w);
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if ({error, cpu_rst_n, done, in_ready} !== 4'b1000 || log_addr.size() !== base) begin
            errors++;
            $display("FAIL oversize_err: err/cpu/done/rdy=%b writes=%0d required 1000 0",
                     {error, cpu_rst_n, done, in_ready}, log_addr.size() - base);
        end
        pulse_start();
        checks++;
        if (error !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL err_restart: error=%b in_ready=%b required 0 1", error, in_ready);
        end
        img = '{8'h00, 8'h00};
        send_image(0, 1'b0, w);
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if ({done, cpu_rst_n, error} !== 3'b110 || log_addr.size() !== base) begin
            errors++;
            $display("FAIL empty_image: done/cpu/err=%b writes=%0d required 110 0",
                     {done, cpu_rst_n, error}, log_addr.size() - base);
        end
    endtask

    task automatic test_start_ignored_and_reload();
        int w;
        int base = log_addr.size();
        load_two_word_image();
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(img[i], w);
        pulse_start();
        for (int i = 5; i < img.size(); i++) send_byte(img[i], w);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h20 ^ 8'h08 ^ 8'h00 ^ 8'h05 ^ 8'h8C ^ 8'h09 ^ 8'h00 ^ 8'h04, w);
`endif
        repeat (2) begin @(posedge clk); #1; end
        check_two_writes("start_in_data", base, 32'h2008_0005, 32'h8C09_0004);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL start_in_data_done: done=%b required 1", done);
        end

        // Reload from DONE: core goes back into reset on the start edge.
        pulse_start();
        checks++;
        if ({cpu_rst_n, done, in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reload_cpu_rst: cpu/done/rdy=%b required 001", {cpu_rst_n, done, in_ready});
        end
        base = log_addr.size();
        img = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_image(0, 1'b0, w);
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (log_addr.size() - base !== 1) begin
            errors++;
            $display("FAIL reload_count: writes=%0d required 1", log_addr.size() - base);
        end else begin
            checks++;
            if (log_addr[base] !== BASE || log_data[base] !== 32'hDEAD_BEEF) begin
                errors++;
                $display("FAIL reload_word: got %h@%h required deadbeef@%h",
                         log_data[base], log_addr[base], BASE);
            end
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int w;
        int base;
        for (int bad = 0; bad < 2; bad++) begin
            base = log_addr.size();
            img = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
            pulse_start();
            send_image(0, bad[0], w);
            @(posedge clk); #1;
            checks++;
            if ({done, error} !== (bad == 0 ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL csum_result%0d: done/err=%b required %b", bad,
                         {done, error}, (bad == 0 ? 2'b10 : 2'b01));
            end
            checks++;
            if (log_addr.size() - base !== 1 || log_data[log_data.size()-1] !== 32'h1122_3344) begin
                errors++;
                $display("FAIL csum_word%0d: writes=%0d last=%h required 1 11223344", bad,
                         log_addr.size() - base, log_data[log_data.size()-1]);
            end
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_mid_data();
        test_back_to_back();
        test_valid_gaps();
        test_header_limits();
        test_start_ignored_and_reload();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_imem_boot_loader

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream stage of the 32-bit single-cycle processor.
- Receives a program image as a byte stream over a valid/ready handshake.
- Packs the bytes big-endian into 32-bit words and writes them into the instruction memory's write port.
- Holds the processor core in reset (cpu_rst_n low) until the image is fully loaded; then releases it so fetch starts at BASE_ADDR.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction word written.
- MAX_WORDS, 256, largest accepted image size in words; 16-bit header count must be <= MAX_WORDS.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader can accept a byte this cycle.
- imem_wr_en  output  1  instruction-memory write strobe, one cycle per word.
- imem_wr_addr  output  32  byte address of the word written.
- imem_wr_data  output  32  instruction word.
- cpu_rst_n  output  1  active-low reset to the processor top; high only in DONE.
- done  output  1  high in DONE.
- error  output  1  high in ERR.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - in_ready=0, imem_wr_en=0, imem_wr_addr=BASE_ADDR, imem_wr_data=0.
  - cpu_rst_n=0, done=0, error=0.
  - Byte counter and word counter cleared.
- Handshake:
  - A byte transfers only when in_valid && in_ready at a clock edge.
  - in_ready=1 in HDR_HI, HDR_LO, DATA (and CSUM with the option); 0 in all other states.
  - in_data must be held while in_valid=1 and in_ready=0.
- States:
  - IDLE: start -> HDR_HI.
  - HDR_HI: accepted byte -> count[15:8]; -> HDR_LO.
  - HDR_LO: accepted byte -> count[7:0]. Then:
    - count==0 -> DONE.
    - count>MAX_WORDS -> ERR.
    - otherwise -> DATA, with imem_wr_addr=BASE_ADDR and word counter=0.
  - DATA: accepted bytes shift in big-endian; 1st byte -> [31:24], 4th byte -> [7:0].
    - On the 4th byte: next cycle imem_wr_en=1 for exactly one cycle, with the assembled data and the current address.
    - Address increments by 4 after each write; word counter increments.
    - After the write of word count-1 -> DONE (or -> CSUM with the option).
  - DONE: cpu_rst_n=1, done=1; start -> HDR_HI (cpu_rst_n drops the same edge).
  - ERR: error=1, cpu_rst_n=0; only start (-> HDR_HI) or rst_n exits.
- Timing:
  - Write latency: 1 cycle from acceptance of the 4th byte.
  - in_ready stays high during the write cycle, so back-to-back streaming at 1 byte/cycle is sustained.
  - Last write and entry to DONE coincide: cpu_rst_n rises the cycle after the final imem_wr_en.
- Boundary conditions:
  - start while mid-load (HDR/DATA): ignored.
  - Bytes with in_ready=0: not consumed.
  - count==MAX_WORDS: accepted.
  - Address arithmetic is 32-bit modulo; no wrap check.
  - rst_n asserted mid-load aborts immediately to reset values; partially written words remain in memory.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined: after the last data byte, state CSUM accepts one byte.
  - It must equal the XOR of all data bytes (header excluded).
  - Match -> DONE; mismatch -> ERR. The XOR accumulator is cleared on start.
  - The count==0 image also requires a checksum byte of 8'h00.
- Undefined: no CSUM state; DATA -> DONE directly.

Decomposition:
- Package loader_pkg holds:
  - the state encoding (IDLE, HDR_HI, HDR_LO, DATA, CSUM, DONE, ERR);
  - constant WORD_BYTES=4;
  - constant HDR_BYTES=2.
- One sub-module is natural: byte_packer.
  - 4-byte big-endian shift register plus 2-bit byte index.
  - Emits word_valid with word[31:0] and clears the index on the 4th byte.

Test Plan:
- Reset mid-DATA (after 6 bytes) -> all outputs at reset values within the same cycle; cpu_rst_n=0; state IDLE.
- start, header 00 02, bytes 20 08 00 05 8C 09 00 04 at 1 byte/cycle -> two writes:
  - 32'h2008_0005 @BASE_ADDR;
  - 32'h8C09_0004 @BASE_ADDR+4;
  - cpu_rst_n=1 and done=1 the cycle after the second write.
- Same image with in_valid toggled every other cycle and in_ready checked -> identical writes; no byte duplicated or lost.
- Header 01 01 (257 > MAX_WORDS) -> ERR, error=1, no imem_wr_en; then start plus header 00 00 -> DONE without writes.
- start pulsed during DATA -> ignored; start in DONE -> cpu_rst_n falls and the reload overwrites from BASE_ADDR.
- With LOADER_CHECKSUM_EN, image 00 01 / 11 22 33 44:
  - checksum 8'h44 -> DONE;
  - checksum 8'h45 -> ERR with the word already written.
